// File: rtl/program_loader.sv
// Frames a UART byte stream (sync, length, payload, checksum) into 16-bit halfword writes for the CPU instruction cache.
// Latency: a halfword appears on program_in/instruction_index the cycle after its second byte is accepted; no backpressure, one byte per rx_valid strobe.
module program_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_HALFWORDS  = 1024,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        download_program,
    output logic [31:0] instruction_index,
    output logic [15:0] program_in,
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [15:0] MAX_HW   = 16'(MAX_HALFWORDS);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [7:0]  hi_byte;
    logic [15:0] hw_cnt;
    logic [7:0]  sum;
    logic [31:0] tmo_cnt;

    logic        in_frame;
    logic [15:0] len_full;

    assign in_frame = (state == LEN_LO) || (state == LEN_HI) || (state == DATA_HI) ||
                      (state == DATA_LO) || (state == CHECK);
    assign len_full = {rx_byte, len_lo};

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            len_lo            <= 8'd0;
            len               <= 16'd0;
            hi_byte           <= 8'd0;
            hw_cnt            <= 16'd0;
            sum               <= 8'd0;
            tmo_cnt           <= 32'd0;
            download_program  <= 1'b0;
            instruction_index <= 32'd0;
            program_in        <= 16'd0;
            load_done         <= 1'b0;
            load_error        <= 1'b0;
        end else if (in_frame && tmo_cnt == TMO_LAST) begin
            // An idle gap inside a frame wins over a byte arriving on the same cycle.
            state            <= ERROR;
            load_error       <= 1'b1;
            download_program <= 1'b0;
            tmo_cnt          <= 32'd0;
        end else begin
            if (rx_valid) begin
                tmo_cnt <= 32'd0;
            end else if (in_frame) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end

            if (rx_valid) begin
                case (state)
                    IDLE, DONE, ERROR: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state      <= LEN_LO;
                            load_done  <= 1'b0;
                            load_error <= 1'b0;
                            sum        <= 8'd0;
                            hw_cnt     <= 16'd0;
                        end
                    end
                    LEN_LO: begin
                        len_lo <= rx_byte;
                        state  <= LEN_HI;
                    end
                    LEN_HI: begin
                        len <= len_full;
                        if (len_full > MAX_HW) begin
                            state            <= ERROR;
                            load_error       <= 1'b1;
                            download_program <= 1'b0;
                        end else if (len_full == 16'd0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                    DATA_HI: begin
                        hi_byte <= rx_byte;
                        sum     <= sum + rx_byte;
                        state   <= DATA_LO;
                    end
                    DATA_LO: begin
                        // Data and address update together so the CPU never sees a torn pair.
                        program_in        <= {hi_byte, rx_byte};
                        instruction_index <= {16'd0, hw_cnt};
                        download_program  <= 1'b1;
                        hw_cnt            <= hw_cnt + 16'd1;
                        sum               <= sum + rx_byte;
                        state             <= (hw_cnt == len - 16'd1) ? CHECK : DATA_HI;
                    end
                    CHECK: begin
                        download_program <= 1'b0;
                        if (sum == rx_byte) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: scoreboard of expected cache writes plus directed frame scenarios.
module tb_program_loader;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        download_program;
    logic [31:0] instruction_index;
    logic [15:0] program_in;
    logic        load_done;
    logic        load_error;

    program_loader #(
        .SYNC_BYTE      (8'hA5),
        .MAX_HALFWORDS  (1024),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .rx_valid          (rx_valid),
        .rx_byte           (rx_byte),
        .download_program  (download_program),
        .instruction_index (instruction_index),
        .program_in        (program_in),
        .load_done         (load_done),
        .load_error        (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] idx;
        logic [15:0] dat;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  pl[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        dp_seen = 1'b0;
    logic        prev_dp = 1'b0;
    logic [31:0] prev_idx = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every new (index, data) pair seen while download_program is high is one cache write.
    always @(negedge clk) begin
        if (download_program) dp_seen = 1'b1;
        if (download_program && (!prev_dp || instruction_index != prev_idx)) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_write", instruction_index, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_idx", instruction_index, e.idx);
                check("wr_dat", {16'd0, program_in}, {16'd0, e.dat});
            end
        end
        prev_dp  = download_program;
        prev_idx = instruction_index;
    end

    // Called at posedge+1; leaves at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [15:0] len, input int nsend, input logic [7:0] chk_xor);
        logic [7:0] s;
        s = 8'd0;
        send_byte(8'hA5);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int i = 0; i < nsend; i++) begin
            check("dp_before_byte", {31'd0, download_program}, {31'd0, (i >= 2)});
            if (i % 2 == 1) exp_q.push_back('{idx: 32'(i / 2), dat: {pl[i-1], pl[i]}});
            s = s + pl[i];
            send_byte(pl[i]);
        end
        if (nsend == 2 * int'(len)) begin
            send_byte(s ^ chk_xor);
            check("dp_after_chk", {31'd0, download_program}, 32'd0);
        end
    endtask

    task automatic check_status(input string tag, input logic done, input logic err);
        check({tag, "_done"}, {31'd0, load_done}, {31'd0, done});
        check({tag, "_err"},  {31'd0, load_error}, {31'd0, err});
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dp",  {31'd0, download_program}, 32'd0);
        check("rst_idx", instruction_index, 32'd0);
        check("rst_pin", {16'd0, program_in}, 32'd0);
        check_status("rst", 1'b0, 1'b0);
        reset = 1'b0;
        idle(2);

        // Good two-halfword frame
        pl = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_frame(16'd2, 4, 8'h00);
        check_status("good", 1'b1, 1'b0);
        check("held_idx", instruction_index, 32'd1);
        check("held_pin", {16'd0, program_in}, 32'h0000_5678);
        idle(3);

        // Same frame, checksum off by one
        run_frame(16'd2, 4, 8'h01);
        check_status("badchk", 1'b0, 1'b1);
        idle(3);

        // Zero-length frame
        dp_seen = 1'b0;
        pl = '{};
        run_frame(16'd0, 0, 8'h00);
        check_status("zero", 1'b1, 1'b0);
        check("zero_no_dp", {31'd0, dp_seen}, 32'd0);
        idle(3);

        // Oversize length
        dp_seen = 1'b0;
        run_frame(16'h0401, 0, 8'h00);
        idle(2);
        check_status("big", 1'b0, 1'b1);
        check("big_no_dp", {31'd0, dp_seen}, 32'd0);

        // Sync value as payload data
        pl = '{8'hA5, 8'hA5};
        run_frame(16'd1, 2, 8'h00);
        check_status("syncdata", 1'b1, 1'b0);
        idle(3);

        // Stall after three payload bytes
        pl = '{8'h11, 8'h22, 8'h33};
        run_frame(16'd3, 3, 8'h00);
        idle(TMO - 10);
        check_status("tmo_early", 1'b0, 1'b0);
        check("tmo_early_dp", {31'd0, download_program}, 32'd1);
        idle(20);
        check_status("tmo", 1'b0, 1'b1);
        check("tmo_dp", {31'd0, download_program}, 32'd0);
        pl = '{8'hAB, 8'hCD};
        run_frame(16'd1, 2, 8'h00);
        check_status("recover", 1'b1, 1'b0);
        idle(3);

        // Reset between the two bytes of halfword 5; the strobe during reset must be ignored
        pl = '{};
        for (int i = 0; i < 16; i++) pl.push_back(8'(8'h40 + i));
        run_frame(16'd8, 11, 8'h00);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'hA5;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        reset    = 1'b0;
        check("rmid_dp",  {31'd0, download_program}, 32'd0);
        check("rmid_idx", instruction_index, 32'd0);
        check("rmid_pin", {16'd0, program_in}, 32'd0);
        check_status("rmid", 1'b0, 1'b0);
        dp_seen = 1'b0;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h33);
        idle(2);
        check("junk_no_dp", {31'd0, dp_seen}, 32'd0);
        check_status("junk", 1'b0, 1'b0);
        pl = '{8'hCA, 8'hFE};
        run_frame(16'd1, 2, 8'h00);
        check_status("after_rst", 1'b1, 1'b0);
        check("after_rst_pin", {16'd0, program_in}, 32'h0000_CAFE);
        idle(3);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
